// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame defaults and counter sizing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  // Counter width for a given modulus, never narrower than one bit.
  function automatic int cnt_w(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick divider: one-cycle tick every CLKS_PER_TICK cycles while enabled.
module uart_baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = 27
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int W = cnt_w(CLKS_PER_TICK);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_TICK - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  // Held at zero whenever disabled so every frame starts on a fresh phase.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable)  cnt_d = '0;
    else if (cnt_q == LAST) cnt_d = '0;
    else                    cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge sys_clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start, DATA_BITS LSB-first data, no parity, STOP_TICKS-long stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = 27,
  parameter int OVERSAMPLE    = OVERSAMPLE_DEF,
  parameter int DATA_BITS     = DATA_BITS_DEF,
  parameter int STOP_TICKS    = 16
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // One tick counter covers both the data bit period and a possibly longer stop bit.
  localparam int TICK_MOD = (STOP_TICKS > OVERSAMPLE) ? STOP_TICKS : OVERSAMPLE;
  localparam int TW = cnt_w(TICK_MOD);
  localparam int BW = cnt_w(DATA_BITS);
  localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tick, accept, bit_end, stop_end;

  uart_baud_tick_gen #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .enable  (state_q != IDLE),
    .clear   (accept),
    .tick    (tick)
  );

  assign accept   = tx_valid && tx_ready_q;
  assign bit_end  = tick && (tick_cnt_q == OS_LAST);
  assign stop_end = tick && (state_q == STOP) && (tick_cnt_q == STOP_LAST);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? tick_cnt_q + TW'(1) : tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d    = START;
        shift_d    = data_in;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
      START: if (bit_end) begin
        state_d    = DATA;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
      DATA: if (bit_end) begin
        tick_cnt_d = '0;
        shift_d    = shift_q >> 1;
        if (bit_cnt_q == BIT_LAST) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      STOP: if (stop_end) begin
        state_d    = IDLE;
        tick_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // The line follows the current state one cycle later, so STOP -> IDLE stays high.
  always_comb begin
    tx_d       = 1'b1;
    if (state_q == START)     tx_d = 1'b0;
    else if (state_q == DATA) tx_d = shift_q[0];
    tx_ready_d = (state_d == IDLE);
    tx_busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
    end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = stop_end;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: fast instance (1 clk/tick) and a 27 clk/tick, 2-stop-bit instance.
module tb_uart_tx;

  localparam int N = 8192;

  logic       sys_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid_a = 1'b0, tx_valid_b = 1'b0;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       tx_ready_a, tx_a, tx_busy_a, tx_done_a;
  logic       tx_ready_b, tx_b, tx_busy_b, tx_done_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc, acc1, acc2, idx_f1, idx_r1, idx_f2, idx_r2, done_rel;

  // Per-cycle recording: 0 tx_a, 1 done_a, 2 ready_a, 3 tx_b, 4 done_b, 5 ready_b
  logic rec [6][N];

  always #5 sys_clk = ~sys_clk;

  uart_tx #(.CLKS_PER_TICK(1)) dut_a (
    .sys_clk(sys_clk), .reset_n(reset_n), .tx_valid(tx_valid_a), .data_in(data_a),
    .tx_ready(tx_ready_a), .tx(tx_a), .tx_busy(tx_busy_a), .tx_done(tx_done_a)
  );

  uart_tx #(.CLKS_PER_TICK(27), .STOP_TICKS(32)) dut_b (
    .sys_clk(sys_clk), .reset_n(reset_n), .tx_valid(tx_valid_b), .data_in(data_b),
    .tx_ready(tx_ready_b), .tx(tx_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step n cycles; each sample lands on the falling edge, away from the active edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      cyc++;
      if (cyc < N) begin
        rec[0][cyc] = tx_a;  rec[1][cyc] = tx_done_a; rec[2][cyc] = tx_ready_a;
        rec[3][cyc] = tx_b;  rec[4][cyc] = tx_done_b; rec[5][cyc] = tx_ready_b;
      end
    end
  endtask

  // After send, acc is the index of cycle 1 (the cycle right after the accept edge).
  task automatic send_a(input logic [7:0] d, output int a);
    data_a = d;
    tx_valid_a = 1'b1;
    run(1);
    a = cyc;
    tx_valid_a = 1'b0;
  endtask

  function automatic logic get(input int s, input int i);
    return (i >= 0 && i < N) ? rec[s][i] : 1'bx;
  endfunction

  function automatic int count(input int s, input int lo, input int hi, input logic v);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (get(s, i) === v) n++;
    return n;
  endfunction

  function automatic int find_first(input int s, input int lo, input int hi, input logic v);
    for (int i = lo; i <= hi; i++) if (get(s, i) === v) return i;
    return -1;
  endfunction

  // Expected line for a 16-clock bit: idle c1, start c2..17, data c18..145, stop/idle after.
  function automatic int frame_mism(input int a, input logic [7:0] d, input int cend);
    int m = 0;
    logic e;
    for (int c = 1; c <= cend; c++) begin
      e = 1'b1;
      if (c >= 2 && c <= 17)        e = 1'b0;
      else if (c >= 18 && c <= 145) e = d[(c - 18) / 16];
      if (get(0, a + c - 1) !== e) m++;
    end
    return m;
  endfunction

  // Mid-bit sampling receiver on the recorded line.
  function automatic logic [7:0] decode(input int s, input int a, input int bitlen);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = get(s, a + 1 + bitlen * (i + 1) + bitlen / 2);
    return d;
  endfunction

  initial begin
    // Reset state
    run(3);
    chk("rst_tx", tx_a, 1);
    chk("rst_ready", tx_ready_a, 1);
    chk("rst_busy", tx_busy_a, 0);
    chk("rst_done", tx_done_a, 0);
    chk("rst_tx_b", tx_b, 1);
    reset_n = 1'b1;
    run(2);

    // Single byte A5
    chk("t1_ready_pre", tx_ready_a, 1);
    send_a(8'hA5, acc);
    chk("t1_ready_drop", tx_ready_a, 0);
    chk("t1_busy", tx_busy_a, 1);
    chk("t1_tx_c1", tx_a, 1);
    run(169);
    chk("t1_line", frame_mism(acc, 8'hA5, 170), 0);
    chk("t1_decode", decode(0, acc, 16), 8'hA5);
    chk("t1_done_cyc", find_first(1, acc, acc + 169, 1'b1) - acc + 1, 160);
    chk("t1_done_cnt", count(1, acc, acc + 169, 1'b1), 1);
    chk("t1_ready_cyc", find_first(2, acc, acc + 169, 1'b1) - acc + 1, 161);

    // Busy ignore: FF offered mid-frame of 3C
    send_a(8'h3C, acc);
    run(40);
    data_a = 8'hFF;
    tx_valid_a = 1'b1;
    run(20);
    tx_valid_a = 1'b0;
    run(109);
    chk("t2_line", frame_mism(acc, 8'h3C, 170), 0);
    chk("t2_decode", decode(0, acc, 16), 8'h3C);
    chk("t2_done_cnt", count(1, acc, acc + 169, 1'b1), 1);
    chk("t2_idle_busy", tx_busy_a, 0);
    chk("t2_idle_ready", tx_ready_a, 1);

    // Back-to-back: 00 then FF with tx_valid held
    data_a = 8'h00;
    tx_valid_a = 1'b1;
    run(1);
    acc1 = cyc;
    run(159);
    chk("t3_done1", tx_done_a, 1);
    data_a = 8'hFF;
    run(1);
    chk("t3_ready161", tx_ready_a, 1);
    run(1);
    acc2 = cyc;
    tx_valid_a = 1'b0;
    run(169);
    chk("t3_spacing", acc2 - acc1, 161);
    chk("t3_line1", frame_mism(acc1, 8'h00, 161), 0);
    chk("t3_line2", frame_mism(acc2, 8'hFF, 170), 0);
    chk("t3_decode1", decode(0, acc1, 16), 8'h00);
    chk("t3_decode2", decode(0, acc2, 16), 8'hFF);
    chk("t3_done_cnt", count(1, acc1, acc2 + 169, 1'b1), 2);
    // 16 stop cycles plus exactly one idle cycle before the next start bit
    chk("t3_high_run", find_first(0, acc1 + 145, acc2 + 20, 1'b0) - (acc1 + 145), 17);

    // Reset at cycle 70 of a 55 frame
    send_a(8'h55, acc);
    run(69);
    chk("t4_tx_pre", tx_a, 0);
    reset_n = 1'b0;
    #1;
    chk("t4_rst_tx", tx_a, 1);
    chk("t4_rst_ready", tx_ready_a, 1);
    chk("t4_rst_busy", tx_busy_a, 0);
    chk("t4_rst_done", tx_done_a, 0);
    run(3);
    reset_n = 1'b1;
    run(2);
    chk("t4_no_done", count(1, acc, cyc, 1'b1), 0);
    send_a(8'hC3, acc2);
    run(169);
    chk("t4_line", frame_mism(acc2, 8'hC3, 170), 0);
    chk("t4_decode", decode(0, acc2, 16), 8'hC3);
    chk("t4_done_cnt", count(1, acc2, acc2 + 169, 1'b1), 1);

    // 27 clk/tick, 2 stop bits, byte 81
    data_b = 8'h81;
    tx_valid_b = 1'b1;
    run(1);
    acc = cyc;
    tx_valid_b = 1'b0;
    chk("t5_busy", tx_busy_b, 1);
    run(4799);
    idx_f1 = find_first(3, acc, acc + 4799, 1'b0);
    idx_r1 = find_first(3, idx_f1, acc + 4799, 1'b1);
    idx_f2 = find_first(3, idx_r1, acc + 4799, 1'b0);
    idx_r2 = find_first(3, idx_f2, acc + 4799, 1'b1);
    chk("t5_fall_cyc", idx_f1 - acc + 1, 2);
    chk("t5_start_w", idx_r1 - idx_f1, 432);
    chk("t5_bit0_w", idx_f2 - idx_r1, 432);
    chk("t5_zeros_w", idx_r2 - idx_f2, 6 * 432);
    chk("t5_high_tail", count(3, idx_r2, acc + 4799, 1'b0), 0);
    done_rel = find_first(4, acc, acc + 4799, 1'b1) - acc + 1;
    chk("t5_done_cyc", done_rel, 4752);
    chk("t5_stop_len", done_rel - 9 * 432, 864);
    chk("t5_done_cnt", count(4, acc, acc + 4799, 1'b1), 1);
    chk("t5_ready_cyc", find_first(5, acc, acc + 4799, 1'b1) - acc + 1, 4753);
    chk("t5_loopback", decode(3, acc, 432), 8'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
